enc4to2_capture: RTL and testbench
==================================

Name: enc4to2_capture

Overview:
- Sequential inverse of the team's active-low 2-to-4 decoder.
- Watches four active-low request lines in the same [0:3] one-cold format that the decoder drives, and latches each new request as pending.
- Presents the highest-priority pending request as a 2-bit code {a,b} under a valid/ack handshake.
- Used wherever a one-cold strobe bus must be turned back into a select code for downstream logic.

Parameters:
- LOW_FIRST, 1, priority order. 1 = index 0 (code 00) is highest priority; 0 = index 3 (code 11) is highest priority.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  capture enable; when 0, new requests are ignored
- req_n  input  [0:3]  active-low request lines; bit i corresponds to code i
- ack  input  1  consumer accepts the presented code
- valid  output  1  code {a,b} is valid
- a  output  1  code MSB
- b  output  1  code LSB
- pending  output  [0:3]  active-high pending-request register
- ovf  output  1  sticky overflow flag
- ovf_clr  input  1  synchronous clear of ovf

Behaviour:
- Reset (async, rst_n=0), all registers cleared immediately:
  - valid=0, a=0, b=0, pending=4'b0000, ovf=0, FSM=IDLE.
  - Internal sample register req_q resets to 4'b0000.
  - Consequence: a line already low at reset release is NOT captured; it must go high then low again.
- Input sampling: req_q <= req_n on every clock edge.
- Edge detect: new[i] = en & req_q[i] & ~req_n[i], i.e. a high-to-low transition seen at this edge.
- Pending update at each edge, per bit:
  - pending[i] is set if new[i].
  - Else pending[i] is cleared if a handshake completes on index i this edge.
  - Else pending[i] holds.
  - Set wins over clear: a new request on the index being acked stays pending and does not raise ovf.
- Overflow:
  - ovf <= 1 when new[i] and pending[i] are both 1, and index i is not being cleared this edge.
  - ovf_clr=1 clears ovf; if ovf_clr and an overflow occur on the same edge, ovf=1 (set wins).
  - ovf stays set until cleared.
- FSM with two states:
  - IDLE:
    - valid=0.
    - At an edge where the registered pending != 0, select the highest-priority pending index per LOW_FIRST.
    - Load {a,b} with that index, set valid=1, go to PRESENT.
    - Selection uses the pending value before that edge's update.
  - PRESENT:
    - valid=1; {a,b} stays stable even if a higher-priority request arrives.
    - At an edge with ack=1: handshake completes, clear pending[{a,b}], valid<=0, go to IDLE.
    - {a,b} keeps its last value while idle.
    - ack while in IDLE is ignored.
- Latency and throughput:
  - A req_n fall set up before edge N gives pending set at N, and valid with code at N+1 (2 edges from the fall).
  - After an ack at edge M, the next code is valid at M+1 at the earliest, so one idle bubble follows each handshake.
  - Maximum throughput is one code per 2 cycles.
- en=0 blocks capture only; pending codes and the handshake continue to drain.
- Multiple simultaneous falls are all captured on the same edge and served in priority order.
- Outputs are registered; there is no combinational path from inputs to valid, a or b.

Test Plan:
1. Reset with req_n=4'b1111, release, drive req_n=4'b1101 (index 2) at cycle 3, ack held 1. Required: pending=0010 after the next edge, then valid=1 with {a,b}=10 one edge later, then valid=0 and pending=0000 after the ack edge.
2. Simultaneous falls: req_n 1111 -> 0110 (indices 0 and 3), ack=1, LOW_FIRST=1. Required: code 00 first, a bubble cycle, then code 11; pending goes 1001 -> 0001 -> 0000.
3. Stability under preemption: LOW_FIRST=1, index 3 presented with ack=0; index 0 then falls. Required: {a,b} stays 11 and valid stays 1 for 5 cycles. After ack, the next code presented is 00.
4. Overflow: capture index 1 with ack=0, then pulse req_n[1] high then low again. Required: ovf=1 and pending=0100 unchanged. Pulse ovf_clr. Required: ovf=0 the next cycle.
5. en=0 and reset behaviour:
   - With en=0, a fall on index 2 gives no pending change.
   - Hold req_n=4'b0111 through reset release: index 0 is not captured.
   - Assert rst_n=0 mid-PRESENT: valid, pending and ovf go to 0 immediately, without waiting for a clock.
6. LOW_FIRST=0: falls on indices 0 and 2 together. Required: code 10 is served before 00.

Source files
------------

// File: rtl/enc4to2_capture.sv
// Captures falling edges on four one-cold active-low request lines and serves
// the highest-priority pending request as a 2-bit code under valid/ack.
module enc4to2_capture #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [0:3] req_n,
  input  logic       ack,
  output logic       valid,
  output logic       a,
  output logic       b,
  output logic [0:3] pending,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0] r_state;
  logic       r_valid;
  logic       r_a;
  logic       r_b;
  logic [0:3] r_reqQ;
  logic [0:3] r_pending;
  logic       r_ovf;

  logic [0:3] w_new;
  logic [0:3] w_clr;
  logic       w_hs;
  logic       w_ovfSet;
  logic [1:0] w_selIdx;

  assign w_new    = {4{en}} & r_reqQ & ~req_n;
  assign w_hs     = (r_state == PRESENT) && ack;
  assign w_ovfSet = |(w_new & r_pending & ~w_clr);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_clr[i] = w_hs && ({r_a, r_b} == 2'(i));
    end
  end

  // Later loop iterations override earlier ones, so the last set bit visited wins.
  always_comb begin
    w_selIdx = 2'd0;
    if (LOW_FIRST) begin
      for (int i = 3; i >= 0; i--) begin
        if (r_pending[i]) w_selIdx = 2'(i);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_pending[i]) w_selIdx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reqQ    <= 4'b0000;
      r_pending <= 4'b0000;
      r_ovf     <= 1'b0;
    end else begin
      r_reqQ <= req_n;
      for (int i = 0; i < 4; i++) begin
        if (w_new[i])      r_pending[i] <= 1'b1;
        else if (w_clr[i]) r_pending[i] <= 1'b0;
      end
      if (w_ovfSet)     r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  // The code is frozen while presenting, so a late higher-priority request waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            {r_a, r_b} <= w_selIdx;
            r_valid    <= 1'b1;
            r_state    <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign valid   = r_valid;
  assign a       = r_a;
  assign b       = r_b;
  assign pending = r_pending;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_enc4to2_capture.sv
// Directed self-checking bench for enc4to2_capture, covering both priority orders.
module tb_enc4to2_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [0:3] req_n;
  logic       ack;
  logic       ovf_clr;

  logic       valid0, a0, b0, ovf0;
  logic [0:3] pending0;
  logic       valid1, a1, b1, ovf1;
  logic [0:3] pending1;

  int nChecks = 0;
  int nPass   = 0;

  enc4to2_capture #(.LOW_FIRST(1'b1)) dutLow (
    .clk(clk), .rst_n(rst_n), .en(en), .req_n(req_n), .ack(ack),
    .valid(valid0), .a(a0), .b(b0), .pending(pending0), .ovf(ovf0),
    .ovf_clr(ovf_clr)
  );

  enc4to2_capture #(.LOW_FIRST(1'b0)) dutHigh (
    .clk(clk), .rst_n(rst_n), .en(en), .req_n(req_n), .ack(ack),
    .valid(valid1), .a(a1), .b(b1), .pending(pending1), .ovf(ovf1),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Hard time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic iEn, input logic [0:3] iReq, input logic iAck,
                               input logic iClr);
    en      = iEn;
    req_n   = iReq;
    ack     = iAck;
    ovf_clr = iClr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [0:3] iReq);
    applyStimulus(1'b1, iReq, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);

    // Reset state
    doReset(4'b1111);
    checkOutput("rst_valid",   {7'd0, valid0}, 8'd0);
    checkOutput("rst_code",    {6'd0, a0, b0}, 8'd0);
    checkOutput("rst_pending", {4'd0, pending0}, 8'd0);
    checkOutput("rst_ovf",     {7'd0, ovf0}, 8'd0);
    tick();
    tick();

    // Test 1: single request on index 2
    applyStimulus(1'b1, 4'b1101, 1'b1, 1'b0);
    tick();
    checkOutput("t1_pend_set",  {4'd0, pending0}, 8'b0010);
    checkOutput("t1_valid_lo",  {7'd0, valid0}, 8'd0);
    tick();
    checkOutput("t1_valid",     {7'd0, valid0}, 8'd1);
    checkOutput("t1_code",      {6'd0, a0, b0}, 8'b10);
    tick();
    checkOutput("t1_valid_off", {7'd0, valid0}, 8'd0);
    checkOutput("t1_pend_clr",  {4'd0, pending0}, 8'b0000);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
    tick();

    // Test 2: simultaneous falls on indices 0 and 3
    applyStimulus(1'b1, 4'b0110, 1'b1, 1'b0);
    tick();
    checkOutput("t2_pend_both", {4'd0, pending0}, 8'b1001);
    tick();
    checkOutput("t2_valid_a",   {7'd0, valid0}, 8'd1);
    checkOutput("t2_code_a",    {6'd0, a0, b0}, 8'b00);
    tick();
    checkOutput("t2_bubble",    {7'd0, valid0}, 8'd0);
    checkOutput("t2_pend_mid",  {4'd0, pending0}, 8'b0001);
    tick();
    checkOutput("t2_valid_b",   {7'd0, valid0}, 8'd1);
    checkOutput("t2_code_b",    {6'd0, a0, b0}, 8'b11);
    tick();
    checkOutput("t2_pend_end",  {4'd0, pending0}, 8'b0000);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();

    // Test 3: presented code stays stable when a higher priority request arrives
    applyStimulus(1'b1, 4'b1110, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("t3_code_first", {6'd0, a0, b0}, 8'b11);
    applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t3_hold_valid", {7'd0, valid0}, 8'd1);
      checkOutput("t3_hold_code",  {6'd0, a0, b0}, 8'b11);
    end
    checkOutput("t3_pend_both", {4'd0, pending0}, 8'b1001);
    applyStimulus(1'b1, 4'b0110, 1'b1, 1'b0);
    tick();
    checkOutput("t3_ack_valid", {7'd0, valid0}, 8'd0);
    checkOutput("t3_ack_pend",  {4'd0, pending0}, 8'b1000);
    tick();
    checkOutput("t3_next_valid", {7'd0, valid0}, 8'd1);
    checkOutput("t3_next_code",  {6'd0, a0, b0}, 8'b00);
    tick();
    checkOutput("t3_drained", {4'd0, pending0}, 8'b0000);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();

    // Test 4: overflow on a repeated request for a still-pending index
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("t4_code",   {6'd0, a0, b0}, 8'b01);
    checkOutput("t4_no_ovf", {7'd0, ovf0}, 8'd0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0);
    tick();
    checkOutput("t4_ovf_set", {7'd0, ovf0}, 8'd1);
    checkOutput("t4_pend",    {4'd0, pending0}, 8'b0100);
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1);
    tick();
    checkOutput("t4_ovf_clr", {7'd0, ovf0}, 8'd0);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b0);
    tick();
    checkOutput("t4_drained", {4'd0, pending0}, 8'b0000);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();

    // Test 5a: capture disabled
    applyStimulus(1'b0, 4'b1101, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("t5_en0_pend",  {4'd0, pending0}, 8'b0000);
    checkOutput("t5_en0_valid", {7'd0, valid0}, 8'd0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();

    // Test 5b: line already low at reset release is not captured
    doReset(4'b0111);
    tick();
    tick();
    checkOutput("t5_rst_low_pend",  {4'd0, pending0}, 8'b0000);
    checkOutput("t5_rst_low_valid", {7'd0, valid0}, 8'd0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();

    // Test 5c: asynchronous reset while presenting with ovf set
    applyStimulus(1'b1, 4'b1101, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b1101, 1'b0, 1'b0);
    tick();
    checkOutput("t5_pre_valid", {7'd0, valid0}, 8'd1);
    checkOutput("t5_pre_ovf",   {7'd0, ovf0}, 8'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("t5_async_valid", {7'd0, valid0}, 8'd0);
    checkOutput("t5_async_pend",  {4'd0, pending0}, 8'b0000);
    checkOutput("t5_async_ovf",   {7'd0, ovf0}, 8'd0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();

    // Test 6: high-first priority order
    applyStimulus(1'b1, 4'b0101, 1'b1, 1'b0);
    tick();
    checkOutput("t6_pend", {4'd0, pending1}, 8'b1010);
    tick();
    checkOutput("t6_valid_a", {7'd0, valid1}, 8'd1);
    checkOutput("t6_code_a",  {6'd0, a1, b1}, 8'b10);
    checkOutput("t6_low_code_a", {6'd0, a0, b0}, 8'b00);
    tick();
    checkOutput("t6_bubble",  {7'd0, valid1}, 8'd0);
    checkOutput("t6_pend_mid", {4'd0, pending1}, 8'b1000);
    tick();
    checkOutput("t6_valid_b", {7'd0, valid1}, 8'd1);
    checkOutput("t6_code_b",  {6'd0, a1, b1}, 8'b00);
    tick();
    checkOutput("t6_drained", {4'd0, pending1}, 8'b0000);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
